// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Optional macro MC_ORI_EN adds the ORIEXEC state (ori with zero-extended immediate).
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] alucont,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       zeroext,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
`ifdef MC_ORI_EN
      ,ORIEXEC = 4'd12
`endif
   } state_t;

   typedef struct packed {
      logic [2:0] alucont;
      logic       alusrca;
      logic [1:0] alusrcb;
`ifdef MC_ORI_EN
      logic       zeroext;
`endif
      logic       iord;
      logic       irwrite;
      logic       memwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
   } ctrl_t;

   state_t cur, nxt;
   ctrl_t  ctrl;
   logic   illegal_dec;

   function automatic logic funct_ok(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Outputs are registered by decoding the state being entered, so they track the state register exactly.
   function automatic ctrl_t decode(input state_t s, input logic [5:0] f);
      ctrl_t c;
      c = '0;
      c.alucont = 3'b010;
      case (s)
         FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
         DECODE:   c.alusrcb = 2'b11;
         MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         MEMRD:    c.iord = 1'b1;
         MEMWB:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
         MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
         EXECUTE:  begin c.alusrca = 1'b1; c.alucont = funct_alu(f); end
         ALUWB:    begin c.regwrite = 1'b1; c.regdst = 1'b1; end
         BRANCH:   begin c.alusrca = 1'b1; c.alucont = 3'b110; c.pcsrc = 2'b01; c.branch = 1'b1; end
         ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         ADDIWB:   c.regwrite = 1'b1;
         JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
`ifdef MC_ORI_EN
         ORIEXEC:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.zeroext = 1'b1; c.alucont = 3'b001; end
`endif
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt         = FETCH;
      illegal_dec = 1'b0;
      case (cur)
         FETCH: nxt = DECODE;
         DECODE: begin
            case (op)
               6'b100011, 6'b101011: nxt = MEMADR;
               6'b000000: begin
                  if (funct_ok(funct)) nxt = EXECUTE;
                  else                 illegal_dec = 1'b1;
               end
               6'b000100: nxt = BRANCH;
               6'b001000: nxt = ADDIEXEC;
               6'b000010: nxt = JUMP;
`ifdef MC_ORI_EN
               6'b001101: nxt = ORIEXEC;
`endif
               default:   illegal_dec = 1'b1;
            endcase
         end
         MEMADR:   nxt = (op == 6'b100011) ? MEMRD : MEMWR;
         MEMRD:    nxt = MEMWB;
         EXECUTE:  nxt = ALUWB;
         ADDIEXEC: nxt = ADDIWB;
`ifdef MC_ORI_EN
         ORIEXEC:  nxt = ADDIWB;
`endif
         default:  nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur  <= FETCH;
         ctrl <= decode(FETCH, funct);
      end else begin
         cur  <= nxt;
         ctrl <= decode(nxt, funct);
      end
   end

   // Enables are gated by reset so a mid-instruction reset cannot commit any write.
   assign irwrite  = ctrl.irwrite & reset;
   assign memwrite = ctrl.memwrite & reset;
   assign regwrite = ctrl.regwrite & reset;
   assign pcen     = (ctrl.pcwrite | (ctrl.branch & zero)) & reset;
   assign illegal  = illegal_dec & reset;

   assign alucont  = ctrl.alucont;
   assign alusrca  = ctrl.alusrca;
   assign alusrcb  = ctrl.alusrcb;
   assign iord     = ctrl.iord;
   assign regdst   = ctrl.regdst;
   assign memtoreg = ctrl.memtoreg;
   assign pcsrc    = ctrl.pcsrc;
   assign state    = cur;
`ifdef MC_ORI_EN
   assign zeroext  = ctrl.zeroext;
`else
   assign zeroext  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected output words are queued by the stimulus
// and checked by an independent monitor on the falling clock edge.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic [2:0] alucont;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       zeroext;
   logic       iord;
   logic       irwrite;
   logic       memwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       illegal;
   logic [3:0] state;

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .alucont(alucont), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext),
      .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .pcsrc(pcsrc), .pcen(pcen),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [20:0] word;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Word layout: state, alucont, alusrca, alusrcb, zeroext, iord, irwrite, memwrite,
   // regdst, memtoreg, regwrite, pcsrc, pcen, illegal.
   function automatic logic [20:0] mk(input logic [3:0] st, input logic [2:0] ac,
                                      input logic sa, input logic [1:0] sb, input logic zx,
                                      input logic io, input logic irw, input logic mw,
                                      input logic rd, input logic m2r, input logic rw,
                                      input logic [1:0] ps, input logic pe, input logic il);
      return {st, ac, sa, sb, zx, io, irw, mw, rd, m2r, rw, ps, pe, il};
   endfunction

   logic [20:0] e_fetch, e_fetch_rst, e_dec, e_dec_ill, e_madr, e_mrd, e_mwb, e_mwb_rst;
   logic [20:0] e_mwr, e_aluwb, e_br_t, e_br_n, e_aexe, e_awb, e_jump, e_ori;

   task automatic step(input string name, input logic [20:0] w);
      exp_t e;
      e.name = name;
      e.word = w;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares whatever the DUT presents mid-cycle against the next queued expectation.
   initial begin
      exp_t        e;
      logic [20:0] got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {state, alucont, alusrca, alusrcb, zeroext, iord, irwrite, memwrite,
                   regdst, memtoreg, regwrite, pcsrc, pcen, illegal};
            vectors++;
            if (got !== e.word) begin
               miscompares++;
               $display("FAIL %s: got %b required %b", e.name, got, e.word);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   logic [5:0] rf [5];
   logic [2:0] ra [5];

   initial begin
      //                st     alu     sa  sb     zx io irw mw rd m2r rw pcsrc  pe il
      e_fetch     = mk(4'd0,  3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0);
      e_fetch_rst = mk(4'd0,  3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      e_dec       = mk(4'd1,  3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      e_dec_ill   = mk(4'd1,  3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
      e_madr      = mk(4'd2,  3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      e_mrd       = mk(4'd3,  3'b010, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      e_mwb       = mk(4'd4,  3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0);
      e_mwb_rst   = mk(4'd4,  3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
      e_mwr       = mk(4'd5,  3'b010, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
      e_aluwb     = mk(4'd7,  3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0);
      e_br_t      = mk(4'd8,  3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0);
      e_br_n      = mk(4'd8,  3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
      e_aexe      = mk(4'd9,  3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      e_awb       = mk(4'd10, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
      e_jump      = mk(4'd11, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0);
      e_ori       = mk(4'd12, 3'b001, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

      rf[0] = 6'b100000; ra[0] = 3'b010;
      rf[1] = 6'b100010; ra[1] = 3'b110;
      rf[2] = 6'b101010; ra[2] = 3'b111;
      rf[3] = 6'b100100; ra[3] = 3'b000;
      rf[4] = 6'b100101; ra[4] = 3'b001;

      reset = 1'b0; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
      @(posedge clk);
      #1;
      step("reset_cycle0", e_fetch_rst);
      step("reset_cycle1", e_fetch_rst);
      reset = 1'b1;

      op = 6'b100011;
      step("lw_fetch", e_fetch);
      step("lw_decode", e_dec);
      step("lw_memadr", e_madr);
      step("lw_memrd", e_mrd);
      step("lw_memwb", e_mwb);

      op = 6'b101011;
      step("sw_fetch", e_fetch);
      step("sw_decode", e_dec);
      step("sw_memadr", e_madr);
      step("sw_memwr", e_mwr);

      op = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         funct = rf[i];
         step("rtype_fetch", e_fetch);
         step("rtype_decode", e_dec);
         step("rtype_execute", mk(4'd6, ra[i], 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
         step("rtype_aluwb", e_aluwb);
      end

      op = 6'b000100; zero = 1'b1;
      step("beq_t_fetch", e_fetch);
      step("beq_t_decode", e_dec);
      step("beq_t_branch", e_br_t);
      zero = 1'b0;
      step("beq_n_fetch", e_fetch);
      step("beq_n_decode", e_dec);
      step("beq_n_branch", e_br_n);

      op = 6'b001000; zero = 1'b1;
      step("addi_fetch", e_fetch);
      step("addi_decode", e_dec);
      step("addi_exec", e_aexe);
      step("addi_wb", e_awb);
      zero = 1'b0;

      op = 6'b000010;
      step("j_fetch", e_fetch);
      step("j_decode", e_dec);
      step("j_jump", e_jump);

      op = 6'b111111;
      step("illop_fetch", e_fetch);
      step("illop_decode", e_dec_ill);

      op = 6'b000000; funct = 6'b000000;
      step("illfunct_fetch", e_fetch);
      step("illfunct_decode", e_dec_ill);

      op = 6'b001101;
      step("ori_fetch", e_fetch);
`ifdef MC_ORI_EN
      step("ori_decode", e_dec);
      step("ori_exec", e_ori);
      step("ori_wb", e_awb);
`else
      step("ori_decode_illegal", e_dec_ill);
`endif

      op = 6'b100011;
      step("abort_fetch", e_fetch);
      step("abort_decode", e_dec);
      step("abort_memadr", e_madr);
      step("abort_memrd", e_mrd);
      reset = 1'b0;
      step("abort_memwb_masked", e_mwb_rst);
      step("abort_reset_fetch", e_fetch_rst);
      reset = 1'b1;
      op = 6'b000010;
      step("post_fetch", e_fetch);
      step("post_decode", e_dec);
      step("post_jump", e_jump);
      step("post_refetch", e_fetch);

      @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL queue_drain: %0d left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
